// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the fetch/data shared-bus arbiter.
// State encoding, default timeout and bus command bundle.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IBUSY = 2'd1,
        ST_DBUSY = 2'd2
    } arb_state_t;

    localparam int DEF_TIMEOUT_CYCLES = 255;

    localparam logic [3:0] SEL_ALL = 4'hF;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_cmd_t;

    localparam bus_cmd_t CMD_RESET = '0;

    function automatic bus_cmd_t fetch_cmd(
        input logic [31:0] addr
    );
        bus_cmd_t c;
        c.we    = 1'b0;
        c.sel   = SEL_ALL;
        c.addr  = addr;
        c.wdata = 32'h0;
        return c;
    endfunction

    function automatic bus_cmd_t data_cmd(
        input logic        we,
        input logic [3:0]  sel,
        input logic [31:0] addr,
        input logic [31:0] wdata
    );
        bus_cmd_t c;
        c.we    = we;
        c.sel   = sel;
        c.addr  = addr;
        c.wdata = wdata;
        return c;
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Fixed-priority (data over fetch) arbiter onto one shared bus.
// Optional bus timeout enabled with the ARB_TIMEOUT_EN macro.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_inst_o,
    output logic        if_stallreq_o,

    input  logic        d_ce_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_sel_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic [31:0] d_rdata_o,
    output logic        d_stallreq_o,

    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,

    output logic        err_o
);

    localparam int unused_tmo_cfg = TIMEOUT_CYCLES;

    arb_state_t  state, state_n;
    logic        req_q, req_n;
    bus_cmd_t    cmd_q, cmd_n;
    logic [31:0] i_hold, d_hold;

    logic        i_ack, d_ack;
    logic        i_tmo, d_tmo;
    logic        tmo;
    logic        free;
    logic        i_ok, d_ok;

    assign i_ack = (state == ST_IBUSY) & bus_ack_i;
    assign d_ack = (state == ST_DBUSY) & bus_ack_i;

    assign i_tmo = (state == ST_IBUSY) & tmo;
    assign d_tmo = (state == ST_DBUSY) & tmo;

    // A requester finishing this cycle sits out the re-evaluation.
    assign free = (state == ST_IDLE) | i_ack | d_ack;
    assign d_ok = d_ce_i & ~d_ack;
    assign i_ok = if_ce_i & ~i_ack;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;

    assign tmo = (state != ST_IDLE) & ~bus_ack_i
               & (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (free | tmo) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign err_o = tmo;
`else
    assign tmo   = 1'b0;
    assign err_o = 1'b0;
`endif

    always_comb begin
        state_n = state;
        req_n   = req_q;
        cmd_n   = cmd_q;
        if (tmo) begin
            state_n = ST_IDLE;
            req_n   = 1'b0;
        end else if (free) begin
            if (d_ok) begin
                state_n = ST_DBUSY;
                req_n   = 1'b1;
                cmd_n   = data_cmd(d_we_i, d_sel_i,
                                   d_addr_i, d_wdata_i);
            end else if (i_ok) begin
                state_n = ST_IBUSY;
                req_n   = 1'b1;
                cmd_n   = fetch_cmd(if_addr_i);
            end else begin
                state_n = ST_IDLE;
                req_n   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            req_q <= 1'b0;
            cmd_q <= CMD_RESET;
        end else begin
            state <= state_n;
            req_q <= req_n;
            cmd_q <= cmd_n;
        end
    end

    // Hold registers keep the last completed read for each requester.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_hold <= '0;
            d_hold <= '0;
        end else begin
            if (i_ack) begin
                i_hold <= bus_rdata_i;
            end else if (i_tmo) begin
                i_hold <= '0;
            end
            if (d_ack) begin
                d_hold <= bus_rdata_i;
            end else if (d_tmo) begin
                d_hold <= '0;
            end
        end
    end

    assign if_stallreq_o = if_ce_i & ~(i_ack | i_tmo);
    assign d_stallreq_o  = d_ce_i & ~(d_ack | d_tmo);

    assign if_inst_o = i_ack ? bus_rdata_i :
                       i_tmo ? 32'h0 : i_hold;
    assign d_rdata_o = d_ack ? bus_rdata_i :
                       d_tmo ? 32'h0 : d_hold;

    assign bus_req_o   = req_q;
    assign bus_we_o    = cmd_q.we;
    assign bus_sel_o   = cmd_q.sel;
    assign bus_addr_o  = cmd_q.addr;
    assign bus_wdata_o = cmd_q.wdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and random checks of bus_arbiter against a rule-level model.
// Timeout scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_bus_arbiter;

    localparam int TO = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_inst_o;
    logic        if_stallreq_o;
    logic        d_ce_i;
    logic        d_we_i;
    logic [3:0]  d_sel_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_stallreq_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        err_o;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the bus and what was issued.
    int          m_owner;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_ihold;
    logic [31:0] m_dhold;
    int          m_cnt;

    bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .reset(reset),
        .if_ce_i(if_ce_i),
        .if_addr_i(if_addr_i),
        .if_inst_o(if_inst_o),
        .if_stallreq_o(if_stallreq_o),
        .d_ce_i(d_ce_i),
        .d_we_i(d_we_i),
        .d_sel_i(d_sel_i),
        .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i),
        .d_rdata_o(d_rdata_o),
        .d_stallreq_o(d_stallreq_o),
        .bus_req_o(bus_req_o),
        .bus_we_o(bus_we_o),
        .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i),
        .bus_ack_i(bus_ack_i),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_sel   = 4'h0;
        m_addr  = 32'h0;
        m_wdata = 32'h0;
        m_ihold = 32'h0;
        m_dhold = 32'h0;
        m_cnt   = 0;
    endtask

    // Called just after a rising edge with inputs set; ends likewise.
    task automatic cycle();
        logic ack, tmo, d_ok, i_ok;
        logic [31:0] e_d, e_i;
        @(negedge clk);
        ack = (m_owner != 0) && bus_ack_i;
        tmo = TMO_EN && (m_owner != 0) && !bus_ack_i
              && (m_cnt == TO - 1);
        e_d = m_dhold;
        e_i = m_ihold;
        if (m_owner == 2 && ack) e_d = bus_rdata_i;
        if (m_owner == 2 && tmo) e_d = 32'h0;
        if (m_owner == 1 && ack) e_i = bus_rdata_i;
        if (m_owner == 1 && tmo) e_i = 32'h0;
        chk("bus_req", bus_req_o, m_req);
        if (m_req) begin
            chk("bus_we", bus_we_o, m_we);
            chk("bus_sel", bus_sel_o, m_sel);
            chk("bus_addr", bus_addr_o, m_addr);
            if (m_we) chk("bus_wdata", bus_wdata_o, m_wdata);
        end
        chk("d_stall", d_stallreq_o,
            d_ce_i && !(m_owner == 2 && (ack || tmo)));
        chk("if_stall", if_stallreq_o,
            if_ce_i && !(m_owner == 1 && (ack || tmo)));
        chk("d_rdata", d_rdata_o, e_d);
        chk("if_inst", if_inst_o, e_i);
        chk("err", err_o, tmo);
        @(posedge clk);
        #1;
        if (tmo) begin
            if (m_owner == 2) m_dhold = 32'h0;
            else m_ihold = 32'h0;
            m_owner = 0;
            m_req   = 1'b0;
            m_cnt   = 0;
        end else if (m_owner == 0 || ack) begin
            if (ack && m_owner == 2) m_dhold = bus_rdata_i;
            if (ack && m_owner == 1) m_ihold = bus_rdata_i;
            d_ok = d_ce_i && !(ack && m_owner == 2);
            i_ok = if_ce_i && !(ack && m_owner == 1);
            m_cnt = 0;
            if (d_ok) begin
                m_owner = 2;
                m_req   = 1'b1;
                m_we    = d_we_i;
                m_sel   = d_sel_i;
                m_addr  = d_addr_i;
                m_wdata = d_wdata_i;
            end else if (i_ok) begin
                m_owner = 1;
                m_req   = 1'b1;
                m_we    = 1'b0;
                m_sel   = 4'hF;
                m_addr  = if_addr_i;
            end else begin
                m_owner = 0;
                m_req   = 1'b0;
            end
        end else begin
            m_cnt++;
        end
    endtask

    task automatic idle_inputs();
        if_ce_i     = 1'b0;
        if_addr_i   = 32'h0;
        d_ce_i      = 1'b0;
        d_we_i      = 1'b0;
        d_sel_i     = 4'h0;
        d_addr_i    = 32'h0;
        d_wdata_i   = 32'h0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h0;
    endtask

    initial begin
        int hi;
        reset = 1'b1;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_req", bus_req_o, 1'b0);
        chk("rst_sel", bus_sel_o, 4'h0);
        chk("rst_addr", bus_addr_o, 32'h0);
        chk("rst_wdata", bus_wdata_o, 32'h0);
        chk("rst_err", err_o, 1'b0);
        reset = 1'b0;

        // Ack while idle is ignored.
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'h1234_5678;
        cycle();
        chk("idle_ack_req", bus_req_o, 1'b0);

        // Fetch with three stall cycles then ack.
        if_ce_i = 1'b1;
        if_addr_i = 32'h100;
        hi = 0;
        for (int k = 0; k < 4; k++) begin
            bus_ack_i = (k == 3);
            bus_rdata_i = (k == 3) ? 32'h2401_0005 : $urandom;
            #1;
            if (if_stallreq_o) hi++;
            if (k == 1) chk("f_we", bus_we_o, 1'b0);
            if (k == 1) chk("f_addr", bus_addr_o, 32'h100);
            if (k == 3) chk("f_inst", if_inst_o, 32'h2401_0005);
            cycle();
        end
        chk("f_stall_cnt", hi, 3);
        idle_inputs();
        cycle();

        // Simultaneous requests: data first, fetch right after.
        if_ce_i = 1'b1;
        if_addr_i = 32'h104;
        d_ce_i = 1'b1;
        d_we_i = 1'b1;
        d_sel_i = 4'hF;
        d_addr_i = 32'h2000;
        d_wdata_i = 32'hDEAD_BEEF;
        cycle();
        chk("both_addr", bus_addr_o, 32'h2000);
        chk("both_wdata", bus_wdata_o, 32'hDEAD_BEEF);
        chk("both_we", bus_we_o, 1'b1);
        bus_ack_i = 1'b1;
        #1;
        chk("both_dstall", d_stallreq_o, 1'b0);
        chk("both_istall", if_stallreq_o, 1'b1);
        cycle();
        chk("both_iaddr", bus_addr_o, 32'h104);
        chk("both_iwe", bus_we_o, 1'b0);
        chk("both_ireq", bus_req_o, 1'b1);
        d_ce_i = 1'b0;
        bus_rdata_i = 32'h0000_0013;
        cycle();
        idle_inputs();
        cycle();

        // Half-word load and hold retention.
        d_ce_i = 1'b1;
        d_sel_i = 4'h3;
        d_addr_i = 32'h3000;
        cycle();
        chk("ld_sel", bus_sel_o, 4'h3);
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'h0000_ABCD;
        #1;
        chk("ld_rdata", d_rdata_o, 32'h0000_ABCD);
        cycle();
        idle_inputs();
        bus_rdata_i = 32'h5555_AAAA;
        #1;
        chk("ld_hold", d_rdata_o, 32'h0000_ABCD);
        cycle();

        // Flushed data request still completes; fetch follows.
        d_ce_i = 1'b1;
        d_addr_i = 32'h4000;
        d_sel_i = 4'hF;
        cycle();
        d_ce_i = 1'b0;
        #1;
        chk("fl_stall", d_stallreq_o, 1'b0);
        cycle();
        cycle();
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'h7777_0000;
        cycle();
        chk("fl_req_drop", bus_req_o, 1'b0);
        bus_ack_i = 1'b0;
        if_ce_i = 1'b1;
        if_addr_i = 32'h500;
        cycle();
        chk("fl_fetch_addr", bus_addr_o, 32'h500);
        chk("fl_fetch_req", bus_req_o, 1'b1);
        bus_ack_i = 1'b1;
        cycle();
        idle_inputs();
        cycle();

        // Asynchronous reset in the middle of a data transaction.
        d_ce_i = 1'b1;
        d_we_i = 1'b1;
        d_sel_i = 4'hF;
        d_addr_i = 32'h6000;
        d_wdata_i = 32'hCAFE_F00D;
        cycle();
        chk("ar_pre_req", bus_req_o, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_req", bus_req_o, 1'b0);
        chk("ar_we", bus_we_o, 1'b0);
        chk("ar_sel", bus_sel_o, 4'h0);
        chk("ar_addr", bus_addr_o, 32'h0);
        chk("ar_wdata", bus_wdata_o, 32'h0);
        chk("ar_rdata", d_rdata_o, 32'h0);
        chk("ar_err", err_o, 1'b0);
        model_reset();
        idle_inputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle();

`ifdef ARB_TIMEOUT_EN
        // Fetch never acked: error pulse on the fourth busy cycle.
        if_ce_i = 1'b1;
        if_addr_i = 32'h800;
        cycle();
        for (int k = 1; k <= TO; k++) begin
            #1;
            chk("to_err", err_o, k == TO);
            chk("to_stall", if_stallreq_o, k != TO);
            cycle();
        end
        chk("to_idle_req", bus_req_o, 1'b0);
        chk("to_hold", if_inst_o, 32'h0);
        idle_inputs();
        cycle();
`endif

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            if_ce_i     = ($urandom_range(0, 3) != 0);
            if_addr_i   = {$urandom_range(0, 255), 2'b00};
            d_ce_i      = ($urandom_range(0, 1) != 0);
            d_we_i      = $urandom_range(0, 1);
            d_sel_i     = $urandom_range(0, 15);
            d_addr_i    = $urandom;
            d_wdata_i   = $urandom;
            bus_ack_i   = ($urandom_range(0, 2) == 0);
            bus_rdata_i = $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
